// File: rtl/spi_slave_pkg.sv
// Shared definitions for the superio SPI target: register offsets, CTL bit positions,
// frame FSM states and the transmit-word selection rule.
// No logic of its own; imported by spi_slave.
package spi_slave_pkg;

  // Register offsets on the superio bus
  localparam logic [2:0] REG_DHI  = 3'd0;
  localparam logic [2:0] REG_DLO  = 3'd1;
  localparam logic [2:0] REG_CTL  = 3'd2;
  localparam logic [2:0] REG_FILL = 3'd3;

  // Bit positions inside the CTL/status register
  localparam int CTL_RDY = 7;
  localparam int CTL_OVR = 6;
  localparam int CTL_TXE = 5;
  localparam int CTL_B16 = 4;
  localparam int CTL_IEN = 3;
  localparam int CTL_FRE = 2;
  localparam int CTL_SEL = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } frame_state_t;

  // Word to shift out next: the CPU word if one is pending, otherwise the fill
  // pattern. The fill byte is replicated so that 8-bit mode (which shifts from
  // bit 7) and 16-bit mode (which shifts from bit 15) both see FILL.
  function automatic logic [15:0] reply_word(input logic        txe,
                                             input logic [15:0] tx_hold,
                                             input logic [7:0]  fill);
    return txe ? {fill, fill} : tx_hold;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Purpose: 2-flop synchronizer plus history flop for one asynchronous pin; level/rise/fall.
// Latency: level 2 clk after the pin; rise/fall pulse for one clk, acted upon at the 3rd clk edge.
// Backpressure: none, free-running.
// Ports: clk, rst_n (async, active low), d (async pin) -> level, rise, fall.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Everything resets low: a pin that is already low at reset release must
  // not look like a falling edge (ss_n held low is not a frame start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_slave.sv
// Purpose: SPI mode-0 target, 8/16-bit words, oversampled pins, byte-wide superio register port.
// Latency: pin edge to action 3 clk, miso 4 clk after falling sck, DO 1 clk after a read.
// Backpressure: none; an unread word is dropped and flagged OVR, a short frame flags FRE.
// Ports: clk, rst_n; bus AD/DI/DO/rw/cs; irq; SPI sck/ss_n/mosi in, miso/miso_oe out.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  // Synchronized pins
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic ss_lvl_unused, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge u_sync_sck (.clk(clk), .rst_n(rst_n), .d(sck),
                        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  sync_edge u_sync_ss  (.clk(clk), .rst_n(rst_n), .d(ss_n),
                        .level(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall));
  sync_edge u_sync_mosi(.clk(clk), .rst_n(rst_n), .d(mosi),
                        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  // State
  frame_state_t state;
  logic         frame_16b;
  logic [4:0]   bit_cnt;
  logic [14:0]  shift_rx;   // the newest bit arrives with mosi_s, so 15 stored bits suffice
  logic [15:0]  shift_tx;
  logic         load_pend;
  logic [15:0]  rx_hold;
  logic [15:0]  tx_hold;
  logic [7:0]   tx_stage;
  logic [7:0]   fill;
  logic         rdy, ovr, txe, b16, ien, fre;

  // Decode
  logic        in_shift;
  logic [4:0]  bit_cnt_nxt;
  logic [4:0]  word_len;
  logic        word_done;
  logic [15:0] rx_word;
  logic [15:0] next_tx;
  logic        rd_acc, wr_acc;
  logic [7:0]  status;
  logic [7:0]  rd_mux;

  assign in_shift    = (state == ST_SHIFT);
  assign bit_cnt_nxt = bit_cnt + 5'd1;
  assign word_len    = frame_16b ? 5'd16 : 5'd8;
  assign word_done   = in_shift & sck_rise & (bit_cnt_nxt == word_len);
  assign rx_word     = frame_16b ? {shift_rx, mosi_s} : {8'h00, shift_rx[6:0], mosi_s};
  assign next_tx     = reply_word(txe, tx_hold, fill);
  assign rd_acc      = cs & rw;
  assign wr_acc      = cs & ~rw;

  always_comb begin
    status          = 8'h00;
    status[CTL_RDY] = rdy;
    status[CTL_OVR] = ovr;
    status[CTL_TXE] = txe;
    status[CTL_B16] = b16;
    status[CTL_IEN] = ien;
    status[CTL_FRE] = fre;
    status[CTL_SEL] = in_shift;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (AD)
      REG_DHI:  rd_mux = rx_hold[15:8];
      REG_DLO:  rd_mux = rx_hold[7:0];
      REG_CTL:  rd_mux = status;
      REG_FILL: rd_mux = fill;
      default:  rd_mux = 8'h00;
    endcase
  end

  // Statement order encodes priority: CPU flag clears come first so that a
  // flag set by the frame logic in the same cycle wins, while the TX commit
  // comes last so that it re-clears TXE after a same-cycle reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_16b <= 1'b0;
      bit_cnt   <= 5'd0;
      shift_rx  <= 15'd0;
      shift_tx  <= 16'hFFFF;
      load_pend <= 1'b0;
      rx_hold   <= 16'hFFFF;
      tx_hold   <= 16'hFFFF;
      tx_stage  <= 8'hFF;
      fill      <= 8'hFF;
      rdy       <= 1'b0;
      ovr       <= 1'b0;
      txe       <= 1'b1;
      b16       <= 1'b0;
      ien       <= 1'b0;
      fre       <= 1'b0;
      DO        <= 8'h00;
      irq       <= 1'b0;
      miso      <= 1'b1;
      miso_oe   <= 1'b0;
    end else begin
      // Register port
      if (rd_acc) DO <= rd_mux;
      if (rd_acc && AD == REG_DLO) rdy <= 1'b0;
      if (wr_acc && AD == REG_CTL) begin
        b16 <= DI[CTL_B16];
        ien <= DI[CTL_IEN];
        if (DI[CTL_OVR]) ovr <= 1'b0;
        if (DI[CTL_FRE]) fre <= 1'b0;
      end
      if (wr_acc && AD == REG_DHI)  tx_stage <= DI;
      if (wr_acc && AD == REG_FILL) fill     <= DI;

      // Frame FSM
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state     <= ST_SHIFT;
            frame_16b <= b16;
            bit_cnt   <= 5'd0;
            shift_tx  <= next_tx;
            txe       <= 1'b1;
            load_pend <= 1'b0;
            miso_oe   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state     <= ST_IDLE;
            if (bit_cnt != 5'd0) fre <= 1'b1;
            bit_cnt   <= 5'd0;
            load_pend <= 1'b0;
            miso_oe   <= 1'b0;
          end else begin
            if (sck_rise) begin
              shift_rx <= {shift_rx[13:0], mosi_s};
              if (word_done) begin
                if (rdy) ovr <= 1'b1;
                else     rx_hold <= rx_word;
                rdy       <= 1'b1;
                bit_cnt   <= 5'd0;
                load_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt_nxt;
              end
            end
            if (sck_fall) begin
              // The falling edge after a word's last bit loads the next word.
              if (load_pend) begin
                shift_tx  <= next_tx;
                txe       <= 1'b1;
                load_pend <= 1'b0;
              end else begin
                shift_tx <= {shift_tx[14:0], 1'b1};
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_acc && AD == REG_DLO) begin
        tx_hold <= {tx_stage, DI};
        txe     <= 1'b0;
      end

      miso <= frame_16b ? shift_tx[15] : shift_tx[7];
      irq  <= ien & (rdy | ovr | fre);
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       irq;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural flags and registers, updated per access / per word.
  bit        m_rdy, m_ovr, m_fre, m_txe, m_b16, m_ien;
  bit [7:0]  m_fill, m_stage;
  bit [15:0] m_rx, m_tx;
  int        chk_mode = 0;   // 0 none, 1 idle (oe low, irq per flags), 2 inside frame (oe high)
  int        hper = 4;

  task automatic model_reset();
    m_rdy = 0; m_ovr = 0; m_fre = 0; m_txe = 1; m_b16 = 0; m_ien = 0;
    m_fill = 8'hFF; m_stage = 8'hFF; m_rx = 16'hFFFF; m_tx = 16'hFFFF;
  endtask

  function automatic bit [7:0] m_status();
    return {m_rdy, m_ovr, m_txe, m_b16, m_ien, m_fre, 2'b00};
  endfunction

  // A pending CPU word goes out once; otherwise the fill byte goes out.
  task automatic m_next_reply(output bit [15:0] r);
    r = m_txe ? {m_fill, m_fill} : m_tx;
    m_txe = 1;
  endtask

  always @(negedge clk) begin
    if (chk_mode == 1) begin
      check("idle_oe", 16'(miso_oe), 16'h0);
      check("idle_irq", 16'(irq), 16'(m_ien & (m_rdy | m_ovr | m_fre)));
    end else if (chk_mode == 2) begin
      check("frame_oe", 16'(miso_oe), 16'h1);
    end
  end

  task automatic settle();
    repeat (2) @(negedge clk);
    chk_mode = 1;
  endtask

  task automatic cpu(input bit rd_n, input bit [2:0] a, input bit [7:0] d, output bit [7:0] q);
    @(negedge clk);
    chk_mode = 0;
    cs = 1'b1; rw = rd_n; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
    q = DO;
  endtask

  task automatic wr(input bit [2:0] a, input bit [7:0] d);
    bit [7:0] q;
    cpu(1'b0, a, d, q);
    case (a)
      3'd0: m_stage = d;
      3'd1: begin m_tx = {m_stage, d}; m_txe = 0; end
      3'd2: begin
        m_b16 = d[4]; m_ien = d[3];
        if (d[6]) m_ovr = 0;
        if (d[2]) m_fre = 0;
      end
      3'd3: m_fill = d;
      default: ;
    endcase
    settle();
  endtask

  task automatic rd(input bit [2:0] a, input string name, output bit [7:0] q);
    bit [7:0] e;
    cpu(1'b1, a, 8'h00, q);
    case (a)
      3'd0: e = m_rx[15:8];
      3'd1: e = m_rx[7:0];
      3'd2: e = m_status();
      3'd3: e = m_fill;
      default: e = 8'h00;
    endcase
    check(name, 16'(q), 16'(e));
    if (a == 3'd1) m_rdy = 0;
    settle();
  endtask

  // One SPI bit, mode 0: present mosi with sck low, sample miso just before the rise.
  task automatic spi_bit(input bit mo, output bit mi);
    mosi = mo;
    repeat (hper) @(negedge clk);
    mi = miso;
    sck = 1'b1;
    repeat (hper) @(negedge clk);
    sck = 1'b0;
  endtask

  // nwords full words from data (16 bits per slot), then 'partial' extra bits before ss_n rises.
  task automatic frame(input int nwords, input bit [63:0] data, input int partial,
                       output bit [63:0] got);
    bit [15:0] reply, w, g;
    bit        mi, l16;
    int        len, nb;
    got = 64'h0;
    @(negedge clk);
    chk_mode = 0;
    ss_n = 1'b0;
    l16 = m_b16;
    len = l16 ? 16 : 8;
    m_next_reply(reply);
    repeat (4) @(negedge clk);
    chk_mode = 2;
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
    for (int k = 0; k <= nwords; k++) begin
      nb = (k < nwords) ? len : partial;
      w  = data[16*k +: 16];
      g  = 16'h0;
      for (int i = 0; i < nb; i++) begin
        spi_bit(w[len-1-i], mi);
        check("miso_bit", 16'(mi), 16'(reply[len-1-i]));
        g = {g[14:0], mi};
      end
      if (k < nwords) begin
        got[16*k +: 16] = g;
        if (!m_rdy) begin
          m_rx  = l16 ? w : {8'h00, w[7:0]};
          m_rdy = 1;
        end else begin
          m_ovr = 1;
        end
        m_next_reply(reply);
      end
    end
    if (partial != 0) m_fre = 1;
    repeat (4) @(negedge clk);
    chk_mode = 0;
    ss_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_mode = 1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit [7:0]  q;
    bit [7:0]  v;
    bit [63:0] got;
    bit [15:0] r;
    bit        mi;
    int        nw, pb, len;

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_DO", 16'(DO), 16'h00);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_miso", 16'(miso), 16'h1);
    check("rst_oe", 16'(miso_oe), 16'h0);
    rd(3'd2, "rst_status", q); check("lit_rst_status", 16'(q), 16'h20);
    rd(3'd3, "rst_fill", q);   check("lit_rst_fill", 16'(q), 16'hFF);
    rd(3'd0, "rst_rxhi", q);   check("lit_rst_rxhi", 16'(q), 16'hFF);

    // 8-bit basic
    wr(3'd1, 8'hA5);
    frame(1, 64'h3C, 0, got);
    check("lit_b8_reply", got[15:0], 16'h00A5);
    rd(3'd2, "b8_status", q);  check("lit_b8_status", 16'(q), 16'hA0);
    rd(3'd1, "b8_rx", q);      check("lit_b8_rx", 16'(q), 16'h3C);
    rd(3'd2, "b8_status2", q); check("lit_b8_status2", 16'(q), 16'h20);

    // 16-bit back-to-back, second word with no CPU reload
    wr(3'd2, 8'h10); wr(3'd0, 8'h12); wr(3'd1, 8'h34);
    frame(2, {32'h0, 16'hCAFE, 16'hBEEF}, 0, got);
    check("lit_b16_reply0", got[15:0], 16'h1234);
    check("lit_b16_reply1", got[31:16], 16'hFFFF);
    rd(3'd2, "b16_status", q); check("lit_b16_status", 16'(q), 16'hF0);
    rd(3'd0, "b16_rxhi", q);   check("lit_b16_rxhi", 16'(q), 16'hBE);
    rd(3'd1, "b16_rxlo", q);   check("lit_b16_rxlo", 16'(q), 16'hEF);
    wr(3'd2, 8'h44);

    // Interrupt
    wr(3'd2, 8'h08);
    check("lit_irq_idle", 16'(irq), 16'h0);
    frame(1, 64'h96, 0, got);
    check("lit_irq_set", 16'(irq), 16'h1);
    rd(3'd1, "irq_rx", q);     check("lit_irq_rx", 16'(q), 16'h96);
    check("lit_irq_clr", 16'(irq), 16'h0);

    // Aborted frame, then a good one
    frame(0, 64'h5A, 5, got);
    check("lit_abort_oe", 16'(miso_oe), 16'h0);
    rd(3'd2, "abort_status", q); check("lit_abort_status", 16'(q), 16'h2C);
    frame(1, 64'hC3, 0, got);
    rd(3'd1, "after_abort_rx", q); check("lit_after_abort_rx", 16'(q), 16'hC3);

    // Reset in the middle of a frame
    wr(3'd1, 8'h00);
    @(negedge clk);
    chk_mode = 0;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    hper = 4;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, mi);
    check("pre_rst_oe", 16'(miso_oe), 16'h1);
    check("pre_rst_miso", 16'(miso), 16'h0);
    check("pre_rst_irq", 16'(irq), 16'h1);
    rst_n = 1'b0;
    #1;
    check("lit_mid_rst_DO", 16'(DO), 16'h00);
    check("lit_mid_rst_irq", 16'(irq), 16'h0);
    check("lit_mid_rst_miso", 16'(miso), 16'h1);
    check("lit_mid_rst_oe", 16'(miso_oe), 16'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_mode = 1;
    rd(3'd2, "low_ss_status", q); check("lit_low_ss_status", 16'(q), 16'h20);
    @(negedge clk);
    chk_mode = 0;
    ss_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_mode = 1;
    rd(3'd3, "mid_rst_fill", q); check("lit_mid_rst_fill", 16'(q), 16'hFF);

    // $1 read in the same cycle as word completion, with an unread word pending
    frame(1, 64'h11, 0, got);
    @(negedge clk);
    chk_mode = 0;
    ss_n = 1'b0;
    m_next_reply(r);
    repeat (6) @(negedge clk);
    v = 8'h22;
    for (int i = 0; i < 7; i++) spi_bit(v[7-i], mi);
    mosi = v[0];
    repeat (hper) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = 3'd1;
    @(negedge clk);
    cs = 1'b0;
    check("lit_sim_DO", 16'(DO), 16'h11);
    repeat (hper - 3) @(negedge clk);
    sck = 1'b0;
    m_ovr = 1;
    m_next_reply(r);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_mode = 1;
    rd(3'd2, "sim_status", q); check("lit_sim_status", 16'(q), 16'hE0);
    rd(3'd1, "sim_rx", q);     check("lit_sim_rx", 16'(q), 16'h11);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 7))
        0: wr(3'd0, 8'($urandom));
        1: wr(3'd1, 8'($urandom));
        2: wr(3'd2, 8'($urandom));
        3: wr(3'd3, 8'($urandom));
        4: rd(3'($urandom_range(0, 3)), "rnd_read", q);
        default: begin
          len  = m_b16 ? 16 : 8;
          nw   = $urandom_range(0, 3);
          pb   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
          if (nw == 0 && pb == 0) nw = 1;
          hper = $urandom_range(4, 6);
          frame(nw, {$urandom, $urandom}, pb, got);
        end
      endcase
    end
    rd(3'd2, "final_status", q);

    chk_mode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
